imem_loader: RTL and testbench

Boot-time instruction-memory writer for the single-cycle RISC-V core. Accepts a framed byte stream (from a UART receiver or test host) over a valid/ready handshake, packs bytes into 32-bit little-endian words and writes them sequentially into instruction memory from word address 0. Holds the core in reset until a frame loads with a correct checksum, then releases it.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_word_packer.sv | 46 ++++
 rtl/imem_loader.sv | 172 +++++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_CSUM
   } state_e;

   localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
   localparam int         WORD_BYTES    = 4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a byte stream into 32-bit little-endian words; pulses word_valid_o
// for one cycle after the last byte of a word lands.
module word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic [1:0]  idx_o,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

   logic [1:0]  idx_q;
   logic        word_valid_q;
   logic [31:0] word_q;

   // Bytes arrive LSB first, so each new byte enters at the top and the
   // first byte ends up in [7:0] after four shifts.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q        <= '0;
         word_valid_q <= 1'b0;
         word_q       <= '0;
      end else begin
         word_valid_q <= 1'b0;
         if (start_i) begin
            idx_q  <= '0;
            word_q <= '0;
         end else if (byte_en_i) begin
            word_q       <= {byte_i, word_q[31:8]};
            idx_q        <= idx_q + 2'd1;
            word_valid_q <= (idx_q == LAST_IDX);
         end
      end
   end

   assign idx_o        = idx_q;
   assign word_valid_o = word_valid_q;
   assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes words into instruction memory from address 0
// and holds the core in reset until a frame with a good checksum has loaded.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         ADDR_W = 8,
   parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              load_done,
   output logic              load_err,
   output state_e            dbg_state_o
);

   // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
   // rx_ready is low only during reset, so the loader never stalls the source.

   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;
   localparam logic [1:0]  LAST_IDX = 2'(WORD_BYTES - 1);

   state_e            state_q, state_d;
   logic              rx_ready_q;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [15:0]       rem_q, rem_d;
   logic [7:0]        csum_q, csum_d;
   logic [ADDR_W-1:0] addr_q;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              hold_q, hold_d;

   logic              accept;
   logic              start;
   logic              byte_en;
   logic [15:0]       len_full;
   logic [1:0]        byte_idx;
   logic              word_valid;
   logic [31:0]       word;

   assign accept   = rx_valid && rx_ready_q;
   assign len_full = {rx_data, len_lo_q};

   word_packer u_packer (
      .clk_i        (clk),
      .rst_ni       (rst),
      .start_i      (start),
      .byte_en_i    (byte_en),
      .byte_i       (rx_data),
      .idx_o        (byte_idx),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         rx_ready_q <= 1'b0;
         len_lo_q   <= '0;
         rem_q      <= '0;
         csum_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         hold_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         rx_ready_q <= 1'b1;
         len_lo_q   <= len_lo_d;
         rem_q      <= rem_d;
         csum_q     <= csum_d;
         done_q     <= done_d;
         err_q      <= err_d;
         hold_q     <= hold_d;
      end
   end

   // The write strobe trails the fourth byte by one cycle, so the address
   // advances on the strobe itself and stays stable while it is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
      end else if (start) begin
         addr_q <= '0;
      end else if (word_valid) begin
         addr_q <= addr_q + ADDR_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      rem_d    = rem_q;
      csum_d   = csum_q;
      done_d   = done_q;
      err_d    = err_q;
      hold_d   = hold_q;
      start    = 1'b0;
      byte_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept && rx_data == MAGIC) begin
               start   = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
               hold_d  = 1'b1;
               csum_d  = '0;
               state_d = ST_LEN0;
            end
         end
         ST_LEN0: begin
            if (accept) begin
               len_lo_d = rx_data;
               state_d  = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (accept) begin
               rem_d = len_full;
               if ({1'b0, len_full} > CAPACITY) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else if (len_full == 16'd0) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            // A MAGIC value here is payload; only IDLE recognises a frame start.
            if (accept) begin
               byte_en = 1'b1;
               csum_d  = csum_q + rx_data;
               if (byte_idx == LAST_IDX) begin
                  rem_d = rem_q - 16'd1;
                  if (rem_q == 16'd1) begin
                     state_d = ST_CSUM;
                  end
               end
            end
         end
         ST_CSUM: begin
            if (accept) begin
               if (rx_data == csum_q) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rx_ready    = rx_ready_q;
   assign imem_we     = word_valid;
   assign imem_addr   = addr_q;
   assign imem_wdata  = word;
   assign core_hold   = hold_q;
   assign load_done   = done_q;
   assign load_err    = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loading, checksum, length limits and reset.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  state_e            dbg_state;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+31:0] exp_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_hold   (core_hold),
    .load_done   (load_done),
    .load_err    (load_err),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // scoreboard: every write strobe must match the head of exp_q
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          bad++;
          $display("FAIL write_value: got addr=%h data=%h, required addr=%h data=%h",
                   imem_addr, imem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", rx_ready); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", imem_we); end
    total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL rst_addr: got %h want 00", imem_addr); end
    total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h want 0", imem_wdata); end
    total++; if (core_hold !== 1'b1) begin bad++; $display("FAIL rst_hold: got %b want 1", core_hold); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", load_done); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", load_err); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rst: got %b want 1", rx_ready); end
  endtask

  task automatic test_good_frame();
    exp_q.push_back({8'h00, 32'h00000013});
    exp_q.push_back({8'h01, 32'h00100093});
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h00000013, 0);
    total++; if (imem_we !== 1'b1 || imem_addr !== 8'h00) begin bad++;
      $display("FAIL good_w0_timing: got we=%b addr=%h want we=1 addr=00", imem_we, imem_addr); end
    send_byte(8'h93, 0);
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL good_we_one_cycle: got %b want 0", imem_we); end
    send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    total++; if (imem_we !== 1'b1 || imem_addr !== 8'h01) begin bad++;
      $display("FAIL good_w1_timing: got we=%b addr=%h want we=1 addr=01", imem_we, imem_addr); end
    total++; if (load_done !== 1'b0 || core_hold !== 1'b1) begin bad++;
      $display("FAIL good_before_csum: got done=%b hold=%b want done=0 hold=1", load_done, core_hold); end
    send_byte(8'hB6, 0);
    total++; if (load_done !== 1'b1 || core_hold !== 1'b0 || load_err !== 1'b0) begin bad++;
      $display("FAIL good_result: got done=%b hold=%b err=%b want 1 0 0", load_done, core_hold, load_err); end
  endtask

  task automatic test_bad_csum_gaps();
    send_byte(8'hA5, 1);
    total++; if (load_done !== 1'b0 || core_hold !== 1'b1) begin bad++;
      $display("FAIL restart_clear: got done=%b hold=%b want done=0 hold=1", load_done, core_hold); end
    send_byte(8'h02, 2); send_byte(8'h00, 3);
    exp_q.push_back({8'h00, 32'h00000013});
    exp_q.push_back({8'h01, 32'h00100093});
    send_word(32'h00000013, 2);
    send_word(32'h00100093, 3);
    send_byte(8'hB7, 1);
    total++; if (load_err !== 1'b1 || core_hold !== 1'b1 || load_done !== 1'b0) begin bad++;
      $display("FAIL badcsum_result: got err=%b hold=%b done=%b want 1 1 0", load_err, core_hold, load_done); end
  endtask

  task automatic test_noise_empty();
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
    total++; if (dbg_state !== ST_IDLE || load_err !== 1'b1 || core_hold !== 1'b1) begin bad++;
      $display("FAIL noise_ignored: got state=%0d err=%b hold=%b want IDLE 1 1", dbg_state, load_err, core_hold); end
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    total++; if (dbg_state !== ST_CSUM) begin bad++; $display("FAIL empty_to_csum: got %0d want CSUM", dbg_state); end
    send_byte(8'h00, 0);
    total++; if (load_done !== 1'b1 || core_hold !== 1'b0 || load_err !== 1'b0) begin bad++;
      $display("FAIL empty_result: got done=%b hold=%b err=%b want 1 0 0", load_done, core_hold, load_err); end
  endtask

  task automatic test_len_overflow();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
    total++; if (load_err !== 1'b1 || core_hold !== 1'b1 || load_done !== 1'b0 || dbg_state !== ST_IDLE) begin bad++;
      $display("FAIL overflow_result: got err=%b hold=%b done=%b state=%0d want 1 1 0 IDLE",
               load_err, core_hold, load_done, dbg_state); end
    exp_q.push_back({8'h00, 32'hDEADBEEF});
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'hDEADBEEF, 0);
    send_byte(8'h38, 0);
    total++; if (load_done !== 1'b1 || core_hold !== 1'b0 || load_err !== 1'b0) begin bad++;
      $display("FAIL overflow_recover: got done=%b hold=%b err=%b want 1 0 0", load_done, core_hold, load_err); end
  endtask

  task automatic test_magic_in_data();
    exp_q.push_back({8'h00, 32'h000000A5});
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hA5, 0);
    total++; if (dbg_state !== ST_DATA) begin bad++; $display("FAIL magic_as_data: got state=%0d want DATA", dbg_state); end
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'hA5, 0);
    total++; if (load_done !== 1'b1 || core_hold !== 1'b0) begin bad++;
      $display("FAIL magic_data_result: got done=%b hold=%b want 1 0", load_done, core_hold); end
  endtask

  task automatic test_full_capacity();
    logic [7:0]  cs;
    logic [7:0]  i8;
    logic [31:0] w;
    cs = 8'h00;
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    total++; if (dbg_state !== ST_DATA || load_err !== 1'b0) begin bad++;
      $display("FAIL cap_len_ok: got state=%0d err=%b want DATA 0", dbg_state, load_err); end
    for (int i = 0; i < 256; i++) begin
      i8 = 8'(i);
      w  = {8'hC3, i8 ^ 8'h5A, ~i8, i8};
      cs = cs + w[7:0] + w[15:8] + w[23:16] + w[31:24];
      exp_q.push_back({i8, w});
      send_word(w, 0);
    end
    total++; if (imem_addr !== 8'hFF || imem_we !== 1'b1) begin bad++;
      $display("FAIL cap_last_addr: got addr=%h we=%b want FF 1", imem_addr, imem_we); end
    send_byte(cs, 0);
    total++; if (load_done !== 1'b1 || load_err !== 1'b0) begin bad++;
      $display("FAIL cap_result: got done=%b err=%b want 1 0", load_done, load_err); end
  endtask

  task automatic test_reset_mid_frame();
    exp_q.push_back({8'h00, 32'h11223344});
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h11223344, 0);
    total++; if (imem_we !== 1'b1) begin bad++; $display("FAIL mid_w0_written: got %b want 1", imem_we); end
    send_byte(8'h88, 0); send_byte(8'h77, 0);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h66;
    #2 rst = 1'b0;
    #1;
    total++; if (rx_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin bad++;
      $display("FAIL mid_rst_datapath: got ready=%b we=%b addr=%h wdata=%h want 0 0 00 0",
               rx_ready, imem_we, imem_addr, imem_wdata); end
    total++; if (core_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 || dbg_state !== ST_IDLE) begin bad++;
      $display("FAIL mid_rst_status: got hold=%b done=%b err=%b state=%0d want 1 0 0 IDLE",
               core_hold, load_done, load_err, dbg_state); end
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_w0_seen: got %0d pending want 0", exp_q.size()); end
    rst = 1'b1;
    exp_q.push_back({8'h00, 32'hDEADBEEF});
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'hDEADBEEF, 0);
    send_byte(8'h38, 0);
    total++; if (load_done !== 1'b1 || core_hold !== 1'b0) begin bad++;
      $display("FAIL mid_recover: got done=%b hold=%b want 1 0", load_done, core_hold); end
  endtask

  task automatic test_restart_after_done();
    send_byte(8'hA5, 0);
    total++; if (load_done !== 1'b0 || core_hold !== 1'b1 || load_err !== 1'b0 || dbg_state !== ST_LEN0) begin bad++;
      $display("FAIL restart_result: got done=%b hold=%b err=%b state=%0d want 0 1 0 LEN0",
               load_done, core_hold, load_err, dbg_state); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum_gaps();
    test_noise_empty();
    test_len_overflow();
    test_magic_in_data();
    test_full_capacity();
    test_reset_mid_frame();
    test_restart_after_done();
    repeat (3) @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL writes_missing: got %0d pending want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
